// File: rtl/shift_issue_stage_pkg.sv
// rtl/shift_issue_stage_pkg.sv - shared constants, shift-op enum and payload struct for the shift issue stage
package shift_issue_stage_pkg;

    localparam int XLEN = 64;
    localparam int SHW  = 6;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    // RV64 immediate shifts steal bit 25 for shamt[5], leaving a 6-bit funct field
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10
    } shift_op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [SHW-1:0]  n;
        shift_op_e       op;
        logic            word;
        logic [4:0]      rd;
        logic            illegal;
    } shift_payload_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - input/output handshake bundle of the shift issue stage
// master: upstream producer + downstream consumer side; slave: the stage itself.
interface shift_issue_stage_if;
    import shift_issue_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [SHW-1:0]  out_n;
    logic [1:0]      out_op;
    logic            out_word;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_a, out_n, out_op, out_word, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_a, out_n, out_op, out_word, out_rd, out_illegal
    );

endinterface

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - combinational RV64I shift classifier: instr/rs1/rs2 -> shift payload
// Ports: instr, rs1_data, rs2_data in; payload out (a, n, op, word, rd, illegal).
module shift_decode
    import shift_issue_stage_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output shift_payload_t  payload
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] funct6;
    logic       legal;
    shift_op_e  op;
    logic [SHW-1:0] n;
    logic       word;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct6 = instr[31:26];

    always_comb begin
        legal = 1'b0;
        op    = OP_SLL;
        n     = '0;
        word  = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OP_32: begin
                word = (opcode == OPC_OP_32);
                n    = word ? {1'b0, rs2_data[4:0]} : rs2_data[5:0];
                if (funct3 == F3_SLL && funct7 == F7_BASE) begin
                    legal = 1'b1;
                    op    = OP_SLL;
                end else if (funct3 == F3_SR && funct7 == F7_BASE) begin
                    legal = 1'b1;
                    op    = OP_SRL;
                end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
                    legal = 1'b1;
                    op    = OP_SRA;
                end
            end
            OPC_OP_IMM: begin
                n = instr[25:20];
                if (funct3 == F3_SLL && funct6 == F6_BASE) begin
                    legal = 1'b1;
                    op    = OP_SLL;
                end else if (funct3 == F3_SR && funct6 == F6_BASE) begin
                    legal = 1'b1;
                    op    = OP_SRL;
                end else if (funct3 == F3_SR && funct6 == F6_ALT) begin
                    legal = 1'b1;
                    op    = OP_SRA;
                end
            end
            OPC_OP_IMM_32: begin
                // full 7-bit funct compare rejects shamt[5]=1, which is reserved for W forms
                word = 1'b1;
                n    = {1'b0, instr[24:20]};
                if (funct3 == F3_SLL && funct7 == F7_BASE) begin
                    legal = 1'b1;
                    op    = OP_SLL;
                end else if (funct3 == F3_SR && funct7 == F7_BASE) begin
                    legal = 1'b1;
                    op    = OP_SRL;
                end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
                    legal = 1'b1;
                    op    = OP_SRA;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        payload.rd = instr[11:7];
        if (legal) begin
            payload.a       = rs1_data;
            payload.n       = n;
            payload.op      = op;
            payload.word    = word;
            payload.illegal = 1'b0;
        end else begin
            payload.a       = '0;
            payload.n       = '0;
            payload.op      = OP_SLL;
            payload.word    = 1'b0;
            payload.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - shift issue stage: decode, registered output with one-entry skid, issue counters
// Ports: clk, rst_n (async active-low); bus (slave modport: in_* handshake/payload, out_* handshake/payload);
// issued_count / illegal_count performance counters.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_issue_stage_if.slave  bus,
    output logic [CNT_W-1:0]    issued_count,
    output logic [CNT_W-1:0]    illegal_count
);

    shift_payload_t dec_payload;
    shift_payload_t out_q;
    shift_payload_t skid_q;
    logic           out_valid_q;
    logic           skid_valid_q;
    logic           accept;
    logic           xfer;
    logic           out_free;

    shift_decode u_decode (
        .instr    (bus.in_instr),
        .rs1_data (bus.in_rs1_data),
        .rs2_data (bus.in_rs2_data),
        .payload  (dec_payload)
    );

    // in_ready depends only on registered state, breaking any comb path from out_ready
    assign bus.in_ready = ~skid_valid_q;
    assign accept       = bus.in_valid & ~skid_valid_q;
    assign xfer         = out_valid_q & bus.out_ready;
    assign out_free     = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (out_free) begin
            // skid always holds the older bundle, so it takes the output slot first;
            // accept is impossible while the skid is full
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec_payload;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_payload;
            skid_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_count  <= '0;
            illegal_count <= '0;
        end else if (xfer) begin
            issued_count <= issued_count + 1'b1;
            if (out_q.illegal) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_q.a;
    assign bus.out_n       = out_q.n;
    assign bus.out_op      = out_q.op;
    assign bus.out_word    = out_q.word;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Pipeline stage directly upstream of the 64-bit logical/arithmetic shift unit in the RV64I execute path. It accepts a decoded-register instruction bundle (instruction word plus rs1/rs2 values) over a valid/ready handshake. It classifies shift instructions and extracts the shift amount, then presents operand, amount and op to the shifter from a registered output backed by a one-entry skid buffer. It also counts issued and illegal bundles.

Parameters:
XLEN, 64, operand width
SHW, 6, shift-amount width (log2 XLEN)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept (registered-state only, no comb path from out_ready)
in_instr  in  32  instruction word
in_rs1_data  in  XLEN  rs1 value (shift operand)
in_rs2_data  in  XLEN  rs2 value (register shift amount source)
out_valid  out  1  bundle valid to shifter
out_ready  in  1  shifter/consumer accepts
out_a  out  XLEN  operand to shifter
out_n  out  SHW  shift amount
out_op  out  2  00 SLL, 01 SRL, 10 SRA
out_word  out  1  W-variant (32-bit result semantics handled downstream)
out_rd  out  5  destination register (instr[11:7])
out_illegal  out  1  bundle is not a legal shift encoding
issued_count  out  CNT_W  bundles transferred on output
illegal_count  out  CNT_W  illegal bundles transferred on output

Behaviour:
- Reset (rst_n low, async): out_valid=0, all out_* payload=0, skid empty, in_ready=1, both counters=0.
- Decode is combinational on the input and captured at acceptance (in_valid & in_ready):
  - OP (0110011): funct3 001/funct7 0000000 -> SLL; funct3 101/funct7 0000000 -> SRL; funct3 101/funct7 0100000 -> SRA. n=rs2_data[5:0].
  - OP-IMM (0010011): funct3 001/instr[31:26]=000000 -> SLLI; 101/000000 -> SRLI; 101/010000 -> SRAI. n=instr[25:20].
  - OP-32 (0111011): same funct3/funct7 as OP; word=1, n={0,rs2_data[4:0]}.
  - OP-IMM-32 (0011011): instr[31:25] = 0000000 or 0100000 as for OP-IMM; instr[25] must be 0; word=1, n={0,instr[24:20]}.
  - Anything else: illegal=1, op=00, n=0, word=0, a=0, rd kept.
- out_a = rs1_data for legal shifts.
- Pipeline: latency 1 cycle (accept in cycle t -> out_valid in t+1). Sustained throughput 1 bundle/cycle while out_ready=1.
- in_ready = ~skid_valid.
- Accept while output empty or draining: load output register.
- Accept while output held (out_valid & ~out_ready): load skid; in_ready drops next cycle.
- On output transfer with skid valid: skid moves to output, skid empties, in_ready returns to 1 next cycle.
- Simultaneous accept and output transfer with skid empty: the new bundle replaces the output register.
- Ordering is strictly FIFO; no bundle is dropped or duplicated.
- Output payload is stable while out_valid & ~out_ready.
- Counters increment on each output transfer (out_valid & out_ready). illegal_count increments additionally when out_illegal=1. Both wrap modulo 2^CNT_W.
- Reset mid-transfer discards output and skid contents immediately.

Decomposition:
- Shared package holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32
  - funct3/funct7 constants
  - shift-op enum (SLL/SRL/SRA)
  - packed payload struct {a, n, op, word, rd, illegal}
- One natural sub-module: shift_decode (pure combinational instruction -> payload), reused by the bench as its reference model.

Test Plan:
- SRLI x5,x6,1 (0x00135293), rs1=0xCAAA_AAAA_AAAA_AAAA, out_ready=1 -> next cycle out_valid=1, a=rs1, n=1, op=01, word=0, rd=5, illegal=0.
- SRA x1,x2,x3 (0x403150B3), rs2_data=0xFFFF_FFFF_FFFF_FF47 -> n=0x07, op=10, rd=1.
- SRAIW with instr[25]=1 (0x4201509B) -> illegal=1, op=00, n=0; illegal_count and issued_count both increment on transfer.
- Backpressure: 3 back-to-back bundles with out_ready=0 -> first held on output, second in skid, in_ready=0 from the following cycle. Release out_ready -> bundles emerge in order, in_ready=1 one cycle after the skid drains.
- Assert rst_n low while out_valid=1 and skid full -> out_valid=0 and in_ready=1 immediately; counters=0.
- Counter wrap with CNT_W=4: 17 legal transfers -> issued_count=1.
